mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single 128-bit backing-memory port between the instruction cache (port i) and the data cache (port d).
- Arbitrates request-channel commands and locks the grant through 4 write-data beats.
- Tracks owners of outstanding reads in an in-order tag FIFO and steers each 4-beat read response to the requester that issued it.
- Sits between the two cache instances and the memory model / DRAM controller.

Parameters:
- MEM_ADDR_BITS, 28, line address width (word address bits minus 2).
- MEM_DATA_BITS, 128, memory beat width.
- BEATS, 4, data beats per line (read and write).
- RD_DEPTH, 4, max outstanding reads; power of 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low (0 = reset), sampled on the rising edge of clk.
- {i,d}_req_valid  in  1  requester command valid.
- {i,d}_req_ready  out  1  command accepted.
- {i,d}_req_addr  in  MEM_ADDR_BITS  line address.
- {i,d}_req_rw  in  1  1 = write, 0 = read.
- {i,d}_req_data_valid  in  1  write beat valid.
- {i,d}_req_data_ready  out  1  write beat accepted.
- {i,d}_req_data_bits  in  MEM_DATA_BITS  write beat.
- {i,d}_req_data_mask  in  MEM_DATA_BITS/8  byte mask.
- {i,d}_resp_valid  out  1  read beat to requester.
- {i,d}_resp_data  out  MEM_DATA_BITS  read beat (mem_resp_data broadcast to both).
- mem_req_valid, mem_req_ready, mem_req_addr, mem_req_rw  out/in/out/out  1/1/MEM_ADDR_BITS/1  memory command.
- mem_req_data_valid, mem_req_data_ready, mem_req_data_bits, mem_req_data_mask  out/in/out/out  1/1/MEM_DATA_BITS/MEM_DATA_BITS/8  memory write data.
- mem_resp_valid, mem_resp_data  in/in  1/MEM_DATA_BITS  memory read beat.
- rd_overflow  out  1  sticky: read beat arrived with tag FIFO empty.

Behaviour:
- Reset (reset == 0 at posedge): state = ARB, rr pointer = i, hold = 0, tag FIFO empty, beat counters = 0, rd_overflow = 0.
  - All ready/valid outputs are 0 during reset and in the first cycle after it.
- FSM states: ARB, WDATA.
- ARB, eligibility:
  - A requester is eligible if req_valid && (req_rw || FIFO not full).
  - Grant is combinational: if hold = 1, the held owner; else among eligible requesters, the one the rr pointer favours; if only one is eligible, that one.
  - mem_req_* = granted requester's command. Granted req_ready = mem_req_ready. Other req_ready = 0.
- ARB, hold:
  - hold is set when mem_req_valid && !mem_req_ready, freezing the owner.
  - hold is cleared on fire.
  - A presented command must never change owner before it is accepted.
- ARB, on fire (mem_req_valid && mem_req_ready):
  - The rr pointer moves to the other requester.
  - Read: push owner id into the tag FIFO; remain in ARB.
  - Write: latch wowner; go to WDATA with wbeat = 0.
- WDATA:
  - No command grants.
  - mem_req_data_* = wowner's data channel; wowner req_data_ready = mem_req_data_ready; other = 0.
  - On each data fire, wbeat++. On the fire with wbeat = BEATS-1, return to ARB.
  - mem_req_valid = 0 throughout.
- Read response path, independent of the FSM:
  - On mem_resp_valid with FIFO non-empty: resp_valid of the FIFO head owner = 1 (same cycle, combinational); rbeat++.
  - At rbeat = BEATS-1: pop and rbeat = 0.
  - If the FIFO is empty: beat dropped, rd_overflow set.
- FIFO:
  - Push and pop in the same cycle are legal; count is unchanged.
  - Push while full is impossible by the eligibility rule.
  - A full FIFO blocks reads only; writes still proceed.
- A reset asserted mid-burst abandons all state. Beats arriving after reset with the FIFO empty set rd_overflow.
- Latency: zero added cycles on command, write data and response paths (pure steering plus registered bookkeeping).

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN defined: when both requesters are eligible and hold = 0, d always wins; the rr pointer is unused.
- Undefined: round-robin as above.

Decomposition:
- Shared package/header (const.vh style): MEM_DATA_BITS, BEATS, the requester id encoding (0 = i, 1 = d), and the FSM state encodings.
- One natural sub-module: mem_arb_tag_fifo (RD_DEPTH x 1-bit, push/pop/full/empty/head).

Test Plan:
- Single i read at addr 0x100, mem_req_ready = 1 → command at 0x100 rw = 0 in the same cycle; 4 response beats with values A0..A3 appear only on i_resp_valid; FIFO then empty.
- i and d both request reads in the same cycle, ready = 1 → first grant i (rr reset value), next cycle d. Responses R0..R7 → beats 0-3 go to i, beats 4-7 go to d.
- d write to 0x20 with mem_req_ready low for 3 cycles while i is valid → grant stays d until fire; 4 beats D0..D3 pass with masks intact; i is not granted until the WDATA exit cycle. Repeat with mem_req_data_ready toggling.
- 4 reads issued (RD_DEPTH = 4) with responses withheld → 5th read gets req_ready = 0; a write from the other port is still granted. After 4 beats return, the 5th read issues.
- mem_resp_valid pulsed with the FIFO empty → no resp_valid on either port; rd_overflow = 1 until reset. Also assert reset = 0 mid-WDATA (beat 2) → next cycle state ARB, all readies 0, rd_overflow = 0.
- With MEM_ARB_FIXED_PRIO_EN, i and d continuously valid → d is granted on every arbitration cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants, requester id encoding and FSM state encoding for the
// backing-memory arbiter.
package mem_arb_pkg;

  localparam int MEM_ADDR_BITS = 28;
  localparam int MEM_DATA_BITS = 128;
  localparam int MEM_MASK_BITS = MEM_DATA_BITS / 8;
  localparam int BEATS         = 4;
  localparam int RD_DEPTH      = 4;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_WDATA = 1'b1
  } arb_state_e;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_I) ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// In-order FIFO of requester ids for outstanding reads; head names the owner
// of the read response currently streaming back.
module mem_arb_tag_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = RD_DEPTH
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  req_id_e push_id,
  input  logic    pop,
  output req_id_e head,
  output logic    empty,
  output logic    full
);

  localparam int PW = $clog2(DEPTH);

  req_id_e       ids_q [DEPTH];
  req_id_e       ids_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;

  always_comb begin
    ids_d   = ids_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      ids_d[wptr_q] = push_id;
      wptr_d        = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    // simultaneous push and pop leaves the occupancy unchanged
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ids_q[k] <= REQ_I;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ids_q   <= ids_d;
    end
  end

  assign head  = ids_q[rptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == (PW+1)'(DEPTH));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 128-bit memory port between the i-cache and d-cache.
// Define MEM_ARB_FIXED_PRIO_EN to make d win every contested arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_req_valid,
  output logic                     i_req_ready,
  input  logic [MEM_ADDR_BITS-1:0] i_req_addr,
  input  logic                     i_req_rw,
  input  logic                     i_req_data_valid,
  output logic                     i_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0] i_req_data_bits,
  input  logic [MEM_MASK_BITS-1:0] i_req_data_mask,
  output logic                     i_resp_valid,
  output logic [MEM_DATA_BITS-1:0] i_resp_data,
  input  logic                     d_req_valid,
  output logic                     d_req_ready,
  input  logic [MEM_ADDR_BITS-1:0] d_req_addr,
  input  logic                     d_req_rw,
  input  logic                     d_req_data_valid,
  output logic                     d_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0] d_req_data_bits,
  input  logic [MEM_MASK_BITS-1:0] d_req_data_mask,
  output logic                     d_resp_valid,
  output logic [MEM_DATA_BITS-1:0] d_resp_data,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
  output logic                     mem_req_rw,
  output logic                     mem_req_data_valid,
  input  logic                     mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0] mem_req_data_bits,
  output logic [MEM_MASK_BITS-1:0] mem_req_data_mask,
  input  logic                     mem_resp_valid,
  input  logic [MEM_DATA_BITS-1:0] mem_resp_data,
  output logic                     rd_overflow
);

  localparam int BW = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  arb_state_e    state_q, state_d;
  req_id_e       rr_q, rr_d;
  req_id_e       hold_id_q, hold_id_d;
  req_id_e       wowner_q, wowner_d;
  logic          hold_q, hold_d;
  logic          active_q, active_d;
  logic          ovf_q, ovf_d;
  logic [BW-1:0] wbeat_q, wbeat_d;
  logic [BW-1:0] rbeat_q, rbeat_d;

  logic    active, in_wdata;
  logic    elig_i, elig_d, gnt_valid;
  req_id_e gnt_id;
  logic    cmd_fire, data_fire, resp_hit;
  logic    fifo_push, fifo_pop, fifo_empty, fifo_full;
  req_id_e fifo_head;

  // Handshake outputs stay quiet while reset is low and for one cycle after.
  assign active   = active_q & reset;
  assign in_wdata = active & (state_q == ST_WDATA);

  assign elig_i = i_req_valid & (i_req_rw | ~fifo_full);
  assign elig_d = d_req_valid & (d_req_rw | ~fifo_full);

  always_comb begin
    gnt_id    = REQ_I;
    gnt_valid = 1'b0;
    if (hold_q) begin
      gnt_id    = hold_id_q;
      gnt_valid = (hold_id_q == REQ_D) ? elig_d : elig_i;
    end else if (elig_i && elig_d) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      gnt_id    = REQ_D;
`else
      gnt_id    = rr_q;
`endif
      gnt_valid = 1'b1;
    end else if (elig_i || elig_d) begin
      gnt_id    = elig_d ? REQ_D : REQ_I;
      gnt_valid = 1'b1;
    end
  end

  assign mem_req_valid = active & (state_q == ST_ARB) & gnt_valid;
  assign mem_req_addr  = (gnt_id == REQ_D) ? d_req_addr : i_req_addr;
  assign mem_req_rw    = (gnt_id == REQ_D) ? d_req_rw : i_req_rw;
  assign i_req_ready   = mem_req_valid & (gnt_id == REQ_I) & mem_req_ready;
  assign d_req_ready   = mem_req_valid & (gnt_id == REQ_D) & mem_req_ready;
  assign cmd_fire      = mem_req_valid & mem_req_ready;

  assign mem_req_data_valid = in_wdata &
                              ((wowner_q == REQ_D) ? d_req_data_valid : i_req_data_valid);
  assign mem_req_data_bits  = (wowner_q == REQ_D) ? d_req_data_bits : i_req_data_bits;
  assign mem_req_data_mask  = (wowner_q == REQ_D) ? d_req_data_mask : i_req_data_mask;
  assign i_req_data_ready   = in_wdata & (wowner_q == REQ_I) & mem_req_data_ready;
  assign d_req_data_ready   = in_wdata & (wowner_q == REQ_D) & mem_req_data_ready;
  assign data_fire          = mem_req_data_valid & mem_req_data_ready;

  assign resp_hit     = mem_resp_valid & ~fifo_empty;
  assign i_resp_valid = active & resp_hit & (fifo_head == REQ_I);
  assign d_resp_valid = active & resp_hit & (fifo_head == REQ_D);
  assign i_resp_data  = mem_resp_data;
  assign d_resp_data  = mem_resp_data;
  assign rd_overflow  = ovf_q;

  assign fifo_push = cmd_fire & ~mem_req_rw;
  assign fifo_pop  = resp_hit & (rbeat_q == LAST_BEAT);

  mem_arb_tag_fifo #(.DEPTH(RD_DEPTH)) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .push_id (gnt_id),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    hold_d    = hold_q;
    hold_id_d = hold_id_q;
    wowner_d  = wowner_q;
    wbeat_d   = wbeat_q;
    rbeat_d   = rbeat_q;
    ovf_d     = ovf_q;
    active_d  = 1'b1;
    case (state_q)
      ST_ARB: begin
        if (cmd_fire) begin
          rr_d   = other_req(gnt_id);
          hold_d = 1'b0;
          if (mem_req_rw) begin
            wowner_d = gnt_id;
            wbeat_d  = '0;
            state_d  = ST_WDATA;
          end
        end else if (mem_req_valid) begin
          // a presented but unaccepted command keeps its owner
          hold_d    = 1'b1;
          hold_id_d = gnt_id;
        end
      end
      ST_WDATA: begin
        if (data_fire) begin
          if (wbeat_q == LAST_BEAT) begin
            wbeat_d = '0;
            state_d = ST_ARB;
          end else begin
            wbeat_d = wbeat_q + BW'(1);
          end
        end
      end
      default: state_d = ST_ARB;
    endcase
    if (mem_resp_valid) begin
      if (!fifo_empty) begin
        rbeat_d = (rbeat_q == LAST_BEAT) ? '0 : rbeat_q + BW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_ARB;
      rr_q      <= REQ_I;
      hold_q    <= 1'b0;
      hold_id_q <= REQ_I;
      wowner_q  <= REQ_I;
      wbeat_q   <= '0;
      rbeat_q   <= '0;
      ovf_q     <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      hold_q    <= hold_d;
      hold_id_q <= hold_id_d;
      wowner_q  <= wowner_d;
      wbeat_q   <= wbeat_d;
      rbeat_q   <= rbeat_d;
      ovf_q     <= ovf_d;
      active_q  <= active_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then random traffic checked against a queue-based model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arb_pkg::*;

`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        rv [2];
  logic [27:0] ra [2];
  logic        rrw [2];
  logic        dv [2];
  logic [127:0] db [2];
  logic [15:0] dm [2];
  logic        rdy [2];
  logic        drdy [2];
  logic        rsp [2];
  logic [127:0] rdat [2];
  logic        mem_req_valid, mem_req_ready, mem_req_rw;
  logic [27:0] mem_req_addr;
  logic        mem_req_data_valid, mem_req_data_ready;
  logic [127:0] mem_req_data_bits, mem_resp_data;
  logic [15:0] mem_req_data_mask;
  logic        mem_resp_valid, rd_overflow;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req_valid(rv[0]), .i_req_ready(rdy[0]), .i_req_addr(ra[0]), .i_req_rw(rrw[0]),
    .i_req_data_valid(dv[0]), .i_req_data_ready(drdy[0]),
    .i_req_data_bits(db[0]), .i_req_data_mask(dm[0]),
    .i_resp_valid(rsp[0]), .i_resp_data(rdat[0]),
    .d_req_valid(rv[1]), .d_req_ready(rdy[1]), .d_req_addr(ra[1]), .d_req_rw(rrw[1]),
    .d_req_data_valid(dv[1]), .d_req_data_ready(drdy[1]),
    .d_req_data_bits(db[1]), .d_req_data_mask(dm[1]),
    .d_resp_valid(rsp[1]), .d_resp_data(rdat[1]),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .rd_overflow(rd_overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding read owners as a queue, write burst as a
  // count of beats still owed, plus grant bookkeeping.
  bit m_init = 0, m_act = 0, m_wr = 0, m_hold = 0, m_ovf = 0;
  int m_wown = 0, m_hown = 0, m_rr = 0, m_wleft = 0, m_rbeats = 0;
  int m_tags[$];
  bit f_cmd [2];
  bit f_data [2];

  always @(negedge clk) begin
    bit e [2];
    bit act, v, xv, xdv;
    int own;
    act = m_act && reset;
    for (int p = 0; p < 2; p++) e[p] = rv[p] && (rrw[p] || m_tags.size() < RD_DEPTH);
    v = 0;
    own = 0;
    if (m_hold) begin
      own = m_hown;
      v = e[own];
    end else if (e[0] && e[1]) begin
      own = FIXED ? 1 : m_rr;
      v = 1;
    end else if (e[0] || e[1]) begin
      own = e[1] ? 1 : 0;
      v = 1;
    end
    xv  = act && !m_wr && v;
    xdv = act && m_wr && dv[m_wown];
    if (m_init) begin
      chk("mem_req_valid", mem_req_valid, xv);
      if (xv) begin
        chk("mem_req_addr", mem_req_addr, ra[own]);
        chk("mem_req_rw", mem_req_rw, rrw[own]);
      end
      chk("mem_req_data_valid", mem_req_data_valid, xdv);
      if (xdv) begin
        chk("mem_req_data_bits", mem_req_data_bits, db[m_wown]);
        chk("mem_req_data_mask", mem_req_data_mask, dm[m_wown]);
      end
      for (int p = 0; p < 2; p++) begin
        chk(p == 0 ? "i_req_ready" : "d_req_ready", rdy[p], xv && own == p && mem_req_ready);
        chk(p == 0 ? "i_req_data_ready" : "d_req_data_ready", drdy[p],
            act && m_wr && m_wown == p && mem_req_data_ready);
        chk(p == 0 ? "i_resp_valid" : "d_resp_valid", rsp[p],
            act && mem_resp_valid && m_tags.size() > 0 && m_tags[0] == p);
        if (mem_resp_valid) chk(p == 0 ? "i_resp_data" : "d_resp_data", rdat[p], mem_resp_data);
      end
      chk("rd_overflow", rd_overflow, m_ovf);
    end
    for (int p = 0; p < 2; p++) begin
      f_cmd[p]  = reset && xv && own == p && mem_req_ready;
      f_data[p] = reset && xdv && m_wown == p && mem_req_data_ready;
    end
    if (!reset) begin
      m_init = 1; m_act = 0; m_wr = 0; m_hold = 0; m_ovf = 0;
      m_rr = 0; m_rbeats = 0; m_wleft = 0;
      m_tags.delete();
    end else begin
      m_act = 1;
      if (mem_resp_valid) begin
        if (m_tags.size() > 0) begin
          m_rbeats++;
          if (m_rbeats == BEATS) begin
            m_rbeats = 0;
            void'(m_tags.pop_front());
          end
        end else begin
          m_ovf = 1;
        end
      end
      if (xv && mem_req_ready) begin
        m_rr = 1 - own;
        m_hold = 0;
        if (rrw[own]) begin
          m_wr = 1; m_wown = own; m_wleft = BEATS;
        end else begin
          m_tags.push_back(own);
        end
      end else if (xv) begin
        m_hold = 1;
        m_hown = own;
      end
      if (xdv && mem_req_data_ready) begin
        m_wleft--;
        if (m_wleft == 0) m_wr = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < 2; p++) begin
      rv[p] = 0; ra[p] = '0; rrw[p] = 0; dv[p] = 0; db[p] = '0; dm[p] = '0;
    end
    mem_req_ready = 0; mem_req_data_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  // Returns in the first (still inactive) cycle after reset.
  task automatic do_reset();
    reset = 0;
    idle_inputs();
    cyc();
    cyc();
    reset = 1;
  endtask

  task automatic resp_beats(input int n);
    mem_resp_valid = 1;
    for (int k = 0; k < n; k++) begin
      mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
      cyc();
    end
    mem_resp_valid = 0;
  endtask

  // Random-traffic driver state
  bit cmd_pend [2];
  int wleft [2];
  int mem_pend;

  task automatic rand_clear();
    for (int p = 0; p < 2; p++) begin
      cmd_pend[p] = 0;
      wleft[p] = 0;
    end
    mem_pend = 0;
  endtask

  task automatic rand_step();
    if (mem_resp_valid && mem_pend > 0) mem_pend--;
    for (int p = 0; p < 2; p++) begin
      if (f_cmd[p]) begin
        cmd_pend[p] = 0;
        rv[p] = 0;
        if (rrw[p]) wleft[p] = BEATS;
        else mem_pend += BEATS;
      end
      if (f_data[p]) begin
        wleft[p]--;
        dv[p] = 0;
      end
      if (!cmd_pend[p] && wleft[p] == 0 && $urandom_range(0, 2) == 0) begin
        cmd_pend[p] = 1;
        rv[p] = 1;
        ra[p] = 28'($urandom);
        rrw[p] = ($urandom_range(0, 2) == 0);
      end
      if (wleft[p] > 0 && !dv[p] && $urandom_range(0, 3) != 0) begin
        dv[p] = 1;
        db[p] = {$urandom, $urandom, $urandom, $urandom};
        dm[p] = 16'($urandom);
      end
    end
    mem_req_ready      = ($urandom_range(0, 3) != 0);
    mem_req_data_ready = ($urandom_range(0, 2) != 0);
    mem_resp_valid     = (mem_pend > 0) && ($urandom_range(0, 2) != 0);
    mem_resp_data      = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    int first;
    reset = 0;
    idle_inputs();

    // Single i read at 0x100, four beats back to i only
    do_reset();
    mem_req_ready = 1; rv[0] = 1; ra[0] = 28'h100; rrw[0] = 0;
    @(negedge clk);
    chk("lit_post_reset_valid", mem_req_valid, 0);
    chk("lit_post_reset_i_ready", rdy[0], 0);
    cyc();
    @(negedge clk);
    chk("lit_rd_valid", mem_req_valid, 1);
    chk("lit_rd_addr", mem_req_addr, 28'h100);
    chk("lit_rd_rw", mem_req_rw, 0);
    chk("lit_rd_i_ready", rdy[0], 1);
    cyc();
    rv[0] = 0;
    mem_resp_valid = 1;
    for (int k = 0; k < 4; k++) begin
      mem_resp_data = 128'hA0 + 128'(k);
      @(negedge clk);
      chk("lit_a_i_resp", rsp[0], 1);
      chk("lit_a_d_resp", rsp[1], 0);
      chk("lit_a_data", rdat[0], 128'hA0 + 128'(k));
      cyc();
    end
    mem_resp_valid = 0;
    cyc();

    // Simultaneous reads from both ports
    do_reset();
    mem_req_ready = 1;
    rv[0] = 1; ra[0] = 28'h111; rrw[0] = 0;
    rv[1] = 1; ra[1] = 28'h222; rrw[1] = 0;
    first = FIXED ? 1 : 0;
    cyc();
    @(negedge clk);
    chk("lit_both_first_addr", mem_req_addr, first ? 28'h222 : 28'h111);
    chk("lit_both_first_ready", rdy[first], 1);
    chk("lit_both_other_ready", rdy[1-first], 0);
    cyc();
    rv[first] = 0;
    @(negedge clk);
    chk("lit_both_second_addr", mem_req_addr, first ? 28'h111 : 28'h222);
    chk("lit_both_second_ready", rdy[1-first], 1);
    cyc();
    rv[1-first] = 0;
    mem_resp_valid = 1;
    for (int k = 0; k < 8; k++) begin
      mem_resp_data = 128'hB0 + 128'(k);
      @(negedge clk);
      chk("lit_r_first_resp", rsp[first], k < 4);
      chk("lit_r_second_resp", rsp[1-first], k >= 4);
      cyc();
    end
    mem_resp_valid = 0;

    // d write held for three cycles while i waits, then four data beats
    do_reset();
    rv[1] = 1; ra[1] = 28'h20; rrw[1] = 1;
    cyc();
    cyc();
    rv[0] = 1; ra[0] = 28'h30; rrw[0] = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("lit_hold_addr", mem_req_addr, 28'h20);
      chk("lit_hold_i_ready", rdy[0], 0);
      cyc();
    end
    mem_req_ready = 1;
    @(negedge clk);
    chk("lit_wr_d_ready", rdy[1], 1);
    chk("lit_wr_i_ready", rdy[0], 0);
    cyc();
    rv[1] = 0; dv[1] = 1; mem_req_data_ready = 1;
    for (int k = 0; k < 4; k++) begin
      db[1] = {4{32'hD0 + 32'(k)}};
      dm[1] = 16'hA5A5 ^ 16'(k);
      @(negedge clk);
      chk("lit_wd_valid", mem_req_data_valid, 1);
      chk("lit_wd_bits", mem_req_data_bits, {4{32'hD0 + 32'(k)}});
      chk("lit_wd_mask", mem_req_data_mask, 16'hA5A5 ^ 16'(k));
      chk("lit_wd_no_cmd", mem_req_valid, 0);
      cyc();
    end
    dv[1] = 0;
    @(negedge clk);
    chk("lit_after_wr_addr", mem_req_addr, 28'h30);
    chk("lit_after_wr_i_ready", rdy[0], 1);
    cyc();
    rv[0] = 0;
    resp_beats(4);

    // Tag FIFO full: fifth read blocked, write from d still granted
    do_reset();
    mem_req_ready = 1; rv[0] = 1; rrw[0] = 0;
    cyc();
    for (int k = 0; k < 4; k++) begin
      ra[0] = 28'h400 + 28'(k);
      @(negedge clk);
      chk("lit_fill_ready", rdy[0], 1);
      cyc();
    end
    ra[0] = 28'h404;
    @(negedge clk);
    chk("lit_full_i_ready", rdy[0], 0);
    chk("lit_full_valid", mem_req_valid, 0);
    cyc();
    rv[1] = 1; ra[1] = 28'h500; rrw[1] = 1;
    @(negedge clk);
    chk("lit_full_d_wr_ready", rdy[1], 1);
    chk("lit_full_d_wr_rw", mem_req_rw, 1);
    cyc();
    rv[1] = 0; dv[1] = 1; mem_req_data_ready = 1;
    repeat (4) cyc();
    dv[1] = 0;
    mem_resp_valid = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lit_drain_i_blocked", rdy[0], 0);
      cyc();
    end
    mem_resp_valid = 0;
    @(negedge clk);
    chk("lit_fifth_ready", rdy[0], 1);
    chk("lit_fifth_addr", mem_req_addr, 28'h404);
    cyc();
    rv[0] = 0;
    resp_beats(16);

    // Response beat with no outstanding read
    mem_resp_valid = 1; mem_resp_data = 128'hDEAD;
    @(negedge clk);
    chk("lit_ovf_i_resp", rsp[0], 0);
    chk("lit_ovf_d_resp", rsp[1], 0);
    cyc();
    mem_resp_valid = 0;
    @(negedge clk);
    chk("lit_ovf_sticky", rd_overflow, 1);
    cyc();

    // Reset during the third write beat
    rv[1] = 1; ra[1] = 28'h600; rrw[1] = 1; mem_req_ready = 1;
    cyc();
    rv[1] = 0; dv[1] = 1; mem_req_data_ready = 1;
    cyc();
    cyc();
    reset = 0;
    cyc();
    reset = 1;
    rv[0] = 1; ra[0] = 28'h700; rrw[0] = 0;
    @(negedge clk);
    chk("lit_mid_rst_i_ready", rdy[0], 0);
    chk("lit_mid_rst_d_dready", drdy[1], 0);
    chk("lit_mid_rst_dvalid", mem_req_data_valid, 0);
    chk("lit_mid_rst_ovf", rd_overflow, 0);
    cyc();
    @(negedge clk);
    chk("lit_mid_rst_arb", mem_req_valid, 1);
    chk("lit_mid_rst_no_wdata", mem_req_data_valid, 0);
    cyc();
    rv[0] = 0; dv[1] = 0;
    resp_beats(4);

    // Random traffic, with one reset in the middle
    for (int seg = 0; seg < 2; seg++) begin
      do_reset();
      rand_clear();
      for (int n = 0; n < 1500; n++) begin
        cyc();
        rand_step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
